// File: rtl/mini_riscv_pkg.sv
// Shared RV32I load/store encodings and scheduler types for the byte-wide memory port.
package mini_riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} sched_state_t;

   function automatic logic [2:0] f3_nbytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Stores have no unsigned forms, so only B/H/W are legal with we set.
   function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
      if (we)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; requester 0 is fetch, requester 1 is the load/store unit.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_lsu;

   // Reset leaves fetch as last winner so the LSU wins the first contested cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_lsu <= 1'b0;
      else if (advance && (gnt != 2'b00))
         last_lsu <= gnt[1];
   end

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_lsu ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one byte-wide memory port between fetch and the LSU, serialising each
// request into byte accesses and reassembling/extending load data.
module mem_port_sched
   import mini_riscv_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_resp_valid,
   output logic [XLEN-1:0]   if_resp_data,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_req_we,
   input  logic [2:0]        ls_req_funct3,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [XLEN-1:0]   ls_req_wdata,
   output logic              ls_resp_valid,
   output logic [XLEN-1:0]   ls_resp_data,
   output logic              ls_resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   sched_state_t      state, next_state;
   logic [1:0]        gnt;
   logic              accept;
   logic              req_legal;
   logic              owner_ls, we_q, err_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q, asm_q, asm_next, ext_data;
   logic [1:0]        cnt, rd_idx, nb_m1;
   logic              rd_pend;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({ls_req_valid, if_req_valid}),
      .advance (accept),
      .gnt     (gnt)
   );

   assign accept    = (state == IDLE) && (gnt != 2'b00);
   assign req_legal = gnt[1] ? f3_legal(ls_req_funct3, ls_req_we) : 1'b1;
   assign nb_m1     = 2'(f3_nbytes(f3_q) - 3'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept) next_state = req_legal ? XFER : RESP;
         XFER:  if (cnt == nb_m1) next_state = we_q ? RESP : DRAIN;
         DRAIN: next_state = RESP;
         RESP:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      if_req_ready  = (state == IDLE) && gnt[0];
      ls_req_ready  = (state == IDLE) && gnt[1];
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
      ls_resp_err   = 1'b0;
      if (state == XFER) begin
         mem_en    = 1'b1;
         mem_we    = we_q;
         mem_addr  = addr_q + ADDR_W'(cnt);
         mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
      end
      if (state == RESP) begin
         if_resp_valid = !owner_ls;
         ls_resp_valid = owner_ls;
         ls_resp_err   = owner_ls && err_q;
      end
   end

   // Read data trails the access by one cycle, so the final byte is merged on the fly.
   always_comb begin
      asm_next = asm_q;
      if (rd_pend)
         asm_next[{rd_idx, 3'b000} +: 8] = mem_rdata;
      case (f3_q[1:0])
         2'b00:   ext_data = {{(XLEN-8){~f3_q[2] & asm_next[7]}}, asm_next[7:0]};
         2'b01:   ext_data = {{(XLEN-16){~f3_q[2] & asm_next[15]}}, asm_next[15:0]};
         default: ext_data = asm_next;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_ls     <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         f3_q         <= F3_W;
         addr_q       <= '0;
         wdata_q      <= '0;
         asm_q        <= '0;
         cnt          <= '0;
         rd_pend      <= 1'b0;
         rd_idx       <= '0;
         if_resp_data <= '0;
         ls_resp_data <= '0;
      end else begin
         rd_pend <= (state == XFER) && !we_q;
         rd_idx  <= cnt;
         if (rd_pend)
            asm_q <= asm_next;
         if (accept) begin
            owner_ls <= gnt[1];
            we_q     <= gnt[1] && ls_req_we;
            f3_q     <= gnt[1] ? ls_req_funct3 : F3_W;
            addr_q   <= gnt[1] ? ls_req_addr : if_req_addr;
            wdata_q  <= gnt[1] ? ls_req_wdata : '0;
            err_q    <= !req_legal;
            cnt      <= '0;
            asm_q    <= '0;
         end else if (state == XFER) begin
            cnt <= cnt + 2'd1;
         end
         if (accept && !req_legal)
            ls_resp_data <= '0;
         else if ((state == XFER || state == DRAIN) && next_state == RESP) begin
            if (owner_ls)
               ls_resp_data <= we_q ? '0 : ext_data;
            else
               if_resp_data <= asm_next;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_sched.sv
// Scoreboard bench for mem_port_sched: drivers queue expected accesses/responses, a negedge monitor checks them.
module tb_mem_port_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready;
   logic [15:0] if_req_addr;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        ls_req_valid, ls_req_ready, ls_req_we;
   logic [2:0]  ls_req_funct3;
   logic [15:0] ls_req_addr;
   logic [31:0] ls_req_wdata;
   logic        ls_resp_valid;
   logic [31:0] ls_resp_data;
   logic        ls_resp_err;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;

   typedef struct {logic [31:0] data; logic err; int cyc;} resp_t;
   typedef struct {int cyc; logic we; logic [15:0] addr; logic [7:0] wdata;} acc_t;

   resp_t       ls_q[$];
   resp_t       if_q[$];
   acc_t        acc_q[$];
   resp_t       mon_r;
   acc_t        mon_a;
   logic [7:0]  tb_mem [0:65535];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          ls_acc, if_acc;

   always #5 clk = ~clk;

   mem_port_sched #(.ADDR_W(16), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
      .ls_req_funct3(ls_req_funct3), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every memory access and response must match the head of its queue.
   always @(negedge clk) begin
      if (mem_en) begin
         if (acc_q.size() == 0)
            check_output("mem_en_unexpected", {31'b0, mem_en}, 32'd0);
         else begin
            mon_a = acc_q.pop_front();
            check_output("mem_cycle", cyc, mon_a.cyc);
            check_output("mem_addr", {16'b0, mem_addr}, {16'b0, mon_a.addr});
            check_output("mem_we", {31'b0, mem_we}, {31'b0, mon_a.we});
            if (mon_a.we)
               check_output("mem_wdata", {24'b0, mem_wdata}, {24'b0, mon_a.wdata});
         end
      end
      if (ls_resp_valid) begin
         if (ls_q.size() == 0)
            check_output("ls_resp_unexpected", {31'b0, ls_resp_valid}, 32'd0);
         else begin
            mon_r = ls_q.pop_front();
            check_output("ls_resp_cycle", cyc, mon_r.cyc);
            check_output("ls_resp_data", ls_resp_data, mon_r.data);
            check_output("ls_resp_err", {31'b0, ls_resp_err}, {31'b0, mon_r.err});
         end
      end
      if (if_resp_valid) begin
         if (if_q.size() == 0)
            check_output("if_resp_unexpected", {31'b0, if_resp_valid}, 32'd0);
         else begin
            mon_r = if_q.pop_front();
            check_output("if_resp_cycle", cyc, mon_r.cyc);
            check_output("if_resp_data", if_resp_data, mon_r.data);
         end
      end
   end

   task automatic apply_stimulus_ls(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] exp_data,
                                    input logic exp_err, output int acc);
      int  n;
      bit  ok;
      ls_req_valid = 1'b1; ls_req_we = we; ls_req_funct3 = f3;
      ls_req_addr = addr;  ls_req_wdata = wdata;
      #1;
      ok  = 1'b0;
      acc = 0;
      for (int i = 0; i < 50; i++) begin
         if (ls_req_ready) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      if (!ok) begin
         check_output("ls_ready_timeout", {31'b0, ls_req_ready}, 32'd1);
         ls_req_valid = 1'b0;
         return;
      end
      acc = cyc;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      if (exp_err)
         ls_q.push_back('{data: 32'h0, err: 1'b1, cyc: acc + 1});
      else begin
         for (int k = 0; k < n; k++)
            acc_q.push_back('{cyc: acc + 1 + k, we: we, addr: addr + 16'(k), wdata: wdata[8*k +: 8]});
         ls_q.push_back('{data: we ? 32'h0 : exp_data, err: 1'b0, cyc: acc + n + (we ? 1 : 2)});
      end
      @(posedge clk); #1;
      ls_req_valid = 1'b0;
   endtask

   task automatic apply_stimulus_if(input logic [15:0] addr, input logic [31:0] exp_data, output int acc);
      bit ok;
      if_req_valid = 1'b1; if_req_addr = addr;
      #1;
      ok  = 1'b0;
      acc = 0;
      for (int i = 0; i < 50; i++) begin
         if (if_req_ready) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      if (!ok) begin
         check_output("if_ready_timeout", {31'b0, if_req_ready}, 32'd1);
         if_req_valid = 1'b0;
         return;
      end
      acc = cyc;
      for (int k = 0; k < 4; k++)
         acc_q.push_back('{cyc: acc + 1 + k, we: 1'b0, addr: addr + 16'(k), wdata: 8'h00});
      if_q.push_back('{data: exp_data, err: 1'b0, cyc: acc + 6});
      @(posedge clk); #1;
      if_req_valid = 1'b0;
   endtask

   task automatic wait_drained();
      for (int i = 0; i < 50; i++) begin
         if (ls_q.size() + if_q.size() + acc_q.size() == 0) break;
         @(negedge clk);
      end
      check_output("queues_drained", ls_q.size() + if_q.size() + acc_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int a;
      for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
      reset = 1'b1;
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_funct3 = '0; ls_req_addr = '0; ls_req_wdata = '0;
      repeat (3) @(negedge clk);
      check_output("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check_output("rst_ls_resp_valid", {31'b0, ls_resp_valid}, 32'd0);
      check_output("rst_if_resp_valid", {31'b0, if_resp_valid}, 32'd0);
      check_output("rst_ls_resp_err", {31'b0, ls_resp_err}, 32'd0);
      check_output("rst_ls_resp_data", ls_resp_data, 32'd0);
      check_output("rst_if_resp_data", if_resp_data, 32'd0);
      check_output("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] store word, then byte/half loads with extension");
      apply_stimulus_ls(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b000, 16'h0012, 32'h0, 32'hFFFFFFAD, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b100, 16'h0012, 32'h0, 32'h000000AD, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b001, 16'h0011, 32'h0, 32'hFFFFADBE, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b101, 16'h0011, 32'h0, 32'h0000ADBE, 1'b0, a);
      apply_stimulus_ls(1'b1, 3'b001, 16'h0040, 32'h99991234, 32'h0, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b001, 16'h0040, 32'h0, 32'h00001234, 1'b0, a);

      $display("[TB] illegal funct3 encodings");
      apply_stimulus_ls(1'b0, 3'b011, 16'h0010, 32'h0, 32'h0, 1'b1, a);
      apply_stimulus_ls(1'b1, 3'b100, 16'h0010, 32'h12345678, 32'h0, 1'b1, a);
      apply_stimulus_ls(1'b1, 3'b011, 16'h0010, 32'h12345678, 32'h0, 1'b1, a);

      $display("[TB] address wrap at top of memory");
      apply_stimulus_ls(1'b1, 3'b010, 16'hFFFF, 32'hCAFEF00D, 32'h0, 1'b0, a);
      apply_stimulus_ls(1'b0, 3'b010, 16'hFFFF, 32'h0, 32'hCAFEF00D, 1'b0, a);
      wait_drained();

      $display("[TB] simultaneous requests after reset");
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      fork
         apply_stimulus_ls(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, ls_acc);
         apply_stimulus_if(16'h0010, 32'hDEADBEEF, if_acc);
      join
      check_output("rr_fetch_accept_gap", if_acc - ls_acc, 32'd7);
      wait_drained();

      $display("[TB] reset in the middle of a store");
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_funct3 = 3'b010;
      ls_req_addr = 16'h0020; ls_req_wdata = 32'h11223344;
      #1;
      check_output("mid_ready", {31'b0, ls_req_ready}, 32'd1);
      a = cyc;
      acc_q.push_back('{cyc: a + 1, we: 1'b1, addr: 16'h0020, wdata: 8'h44});
      @(posedge clk); #1;
      ls_req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check_output("mid_mem_en_drop", {31'b0, mem_en}, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_funct3 = 3'b010; ls_req_addr = 16'h0020;
      #1;
      check_output("ready_after_reset", {31'b0, ls_req_ready}, 32'd1);
      apply_stimulus_ls(1'b0, 3'b010, 16'h0020, 32'h0, 32'h00000044, 1'b0, a);
      wait_drained();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
